// File: rtl/voxel_column_renderer_pkg.sv
// Shared types and helpers for the voxel column renderer.
package voxel_column_renderer_pkg;

    localparam int unsigned POS_W_DEF    = 32;
    localparam int unsigned POS_FRAC_DEF = 16;

    // Render sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRowInit,
        StFetch,
        StProject,
        StFill,
        StNextCol,
        StDone
    } render_state_e;

    // Signed fixed-point world position (POS_FRAC_DEF fractional bits).
    typedef logic signed [POS_W_DEF-1:0] pos_t;

    // Signed screen row, wide enough to hold unclamped projections.
    typedef logic signed [31:0] scr_coord_t;

    // Clamp a projected row into [0, hi].
    function automatic scr_coord_t clamp_row(input scr_coord_t y, input scr_coord_t hi);
        if (y < 0) begin
            return scr_coord_t'(0);
        end else if (y > hi) begin
            return hi;
        end
        return y;
    endfunction

endpackage

// File: rtl/voxel_ybuffer.sv
// Per-column y-buffer: lowest row already drawn in each screen column.
module voxel_ybuffer #(
    parameter int unsigned DEPTH = 320,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Single write port plus registered read port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/voxel_column_renderer.sv
// Front-to-back voxel terrain renderer: one map sample per column per distance slice,
// visible spans filled into the framebuffer with per-column y-buffer occlusion.
module voxel_column_renderer
    import voxel_column_renderer_pkg::*;
#(
    parameter int unsigned SCREEN_W   = 320,
    parameter int unsigned SCREEN_H   = 240,
    parameter int unsigned DIST_STEPS = 512,
    parameter int          HORIZON_Y  = 120,
    parameter int unsigned POS_W      = POS_W_DEF,
    parameter int unsigned POS_FRAC   = POS_FRAC_DEF,
    parameter int unsigned MAP_AW     = 9,
    parameter int unsigned HEIGHT_W   = 8,
    parameter int unsigned COLOR_W    = 3,
    parameter int unsigned SCALE_W    = 18,
    parameter int unsigned SCALE_FRAC = 8,
    parameter int unsigned MAP_LAT    = 2
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_render_ack,
    output logic                              o_render_done,
    input  logic [POS_W-1:0]                  i_cam_x,
    input  logic [POS_W-1:0]                  i_cam_y,
    input  logic [HEIGHT_W-1:0]               i_cam_height,
    input  logic [POS_W-1:0]                  i_left_step_x,
    input  logic [POS_W-1:0]                  i_left_step_y,
    input  logic [POS_W-1:0]                  i_perp_step_x,
    input  logic [POS_W-1:0]                  i_perp_step_y,
    output logic [MAP_AW-1:0]                 o_map_x,
    output logic [MAP_AW-1:0]                 o_map_y,
    input  logic [HEIGHT_W-1:0]               i_map_height,
    input  logic [COLOR_W-1:0]                i_map_color,
    output logic [$clog2(DIST_STEPS+1)-1:0]   o_scale_addr,
    input  logic [SCALE_W-1:0]                i_scale_q,
    output logic                              o_fb_we,
    output logic [$clog2(SCREEN_W)-1:0]       o_fb_x,
    output logic [$clog2(SCREEN_H)-1:0]       o_fb_y,
    output logic [COLOR_W-1:0]                o_fb_color,
    input  logic                              i_fb_ready
);

    localparam int unsigned X_W  = $clog2(SCREEN_W);
    localparam int unsigned Y_W  = $clog2(SCREEN_H);
    localparam int unsigned YB_W = $clog2(SCREEN_H + 1);
    localparam int unsigned D_W  = $clog2(DIST_STEPS + 1);
    localparam int unsigned P_W  = HEIGHT_W + SCALE_W + 2;

    render_state_e r_state, w_state_next;

    logic [HEIGHT_W-1:0] r_cam_height;
    logic [POS_W-1:0]    r_cam_x, r_cam_y, r_left_x, r_left_y, r_perp_x, r_perp_y;
    logic [POS_W-1:0]    r_row_x, r_row_y, r_cstep_x, r_cstep_y, r_samp_x, r_samp_y;
    logic [X_W-1:0]      r_col;
    logic [D_W-1:0]      r_d;
    logic [7:0]          r_wait;
    logic [YB_W-1:0]     r_y, r_fy, r_ylim;
    logic [COLOR_W-1:0]  r_color;
    logic                r_done;

    logic signed [HEIGHT_W:0]  w_diff;
    logic signed [SCALE_W:0]   w_scale;
    logic signed [P_W-1:0]     w_prod, w_shift;
    scr_coord_t                w_yraw, w_yclamp;
    logic [YB_W-1:0]           w_ynew, w_ybuf_q, w_yb_wdata;
    logic                      w_visible, w_fill_last, w_last_col, w_yb_we;

    // Projection: signed height difference scaled by ~K/d around the horizon.
    assign w_diff      = $signed({1'b0, r_cam_height}) - $signed({1'b0, i_map_height});
    assign w_scale     = $signed({1'b0, i_scale_q});
    assign w_prod      = w_diff * w_scale;
    assign w_shift     = w_prod >>> SCALE_FRAC;
    assign w_yraw      = scr_coord_t'(HORIZON_Y) + scr_coord_t'(w_shift);
    assign w_yclamp    = clamp_row(w_yraw, scr_coord_t'(SCREEN_H));
    assign w_ynew      = YB_W'(w_yclamp);
    assign w_visible   = w_ynew < w_ybuf_q;
    assign w_fill_last = r_fy == (r_ylim - YB_W'(1));
    assign w_last_col  = r_col == X_W'(SCREEN_W - 1);

    assign o_map_x       = r_samp_x[POS_FRAC +: MAP_AW];
    assign o_map_y       = r_samp_y[POS_FRAC +: MAP_AW];
    assign o_scale_addr  = r_d;
    assign o_fb_x        = r_col;
    assign o_fb_y        = Y_W'(r_fy);
    assign o_fb_color    = r_color;
    assign o_render_done = r_done;

    voxel_ybuffer #(
        .DEPTH (SCREEN_W),
        .WIDTH (YB_W)
    ) u_ybuf (
        .i_clk   (i_clk),
        .i_we    (w_yb_we),
        .i_waddr (r_col),
        .i_wdata (w_yb_wdata),
        .i_raddr (r_col),
        .o_rdata (w_ybuf_q)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (i_render_ack) w_state_next = StClear;
            StClear:   if (w_last_col) w_state_next = StRowInit;
            StRowInit: w_state_next = StFetch;
            StFetch:   if (r_wait == 8'(MAP_LAT - 1)) w_state_next = StProject;
            StProject: w_state_next = w_visible ? StFill : StNextCol;
            StFill:    if (i_fb_ready && w_fill_last) w_state_next = StNextCol;
            StNextCol: begin
                if (!w_last_col) begin
                    w_state_next = StFetch;
                end else if (r_d == D_W'(DIST_STEPS)) begin
                    w_state_next = StDone;
                end else begin
                    w_state_next = StRowInit;
                end
            end
            StDone:    w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    // Output decode: framebuffer strobe and y-buffer write port.
    always_comb begin
        o_fb_we    = 1'b0;
        w_yb_we    = 1'b0;
        w_yb_wdata = r_y;
        unique case (r_state)
            StClear: begin
                w_yb_we    = 1'b1;
                w_yb_wdata = YB_W'(SCREEN_H);
            end
            StFill: begin
                o_fb_we = 1'b1;
                w_yb_we = i_fb_ready && w_fill_last;
            end
            default: ;
        endcase
    end

    // Datapath: frame latches, position stepping, column/slice counters, fill row.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cam_height <= '0;
            r_cam_x      <= '0;
            r_cam_y      <= '0;
            r_left_x     <= '0;
            r_left_y     <= '0;
            r_perp_x     <= '0;
            r_perp_y     <= '0;
            r_row_x      <= '0;
            r_row_y      <= '0;
            r_cstep_x    <= '0;
            r_cstep_y    <= '0;
            r_samp_x     <= '0;
            r_samp_y     <= '0;
            r_col        <= '0;
            r_d          <= '0;
            r_wait       <= '0;
            r_y          <= '0;
            r_fy         <= '0;
            r_ylim       <= '0;
            r_color      <= '0;
            r_done       <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_render_ack) begin
                        r_cam_height <= i_cam_height;
                        r_cam_x      <= i_cam_x;
                        r_cam_y      <= i_cam_y;
                        r_left_x     <= i_left_step_x;
                        r_left_y     <= i_left_step_y;
                        r_perp_x     <= i_perp_step_x;
                        r_perp_y     <= i_perp_step_y;
                        r_col        <= '0;
                        r_done       <= 1'b0;
                    end
                end
                StClear: begin
                    r_col     <= r_col + X_W'(1);
                    r_row_x   <= r_cam_x;
                    r_row_y   <= r_cam_y;
                    r_cstep_x <= '0;
                    r_cstep_y <= '0;
                    r_d       <= D_W'(1);
                end
                StRowInit: begin
                    r_row_x   <= r_row_x + r_left_x;
                    r_row_y   <= r_row_y + r_left_y;
                    r_cstep_x <= r_cstep_x + r_perp_x;
                    r_cstep_y <= r_cstep_y + r_perp_y;
                    r_samp_x  <= r_row_x + r_left_x;
                    r_samp_y  <= r_row_y + r_left_y;
                    r_col     <= '0;
                    r_wait    <= '0;
                end
                StFetch: r_wait <= r_wait + 8'd1;
                StProject: begin
                    r_y     <= w_ynew;
                    r_fy    <= w_ynew;
                    r_ylim  <= w_ybuf_q;
                    r_color <= i_map_color;
                end
                StFill: begin
                    // Stalled writes hold every fb_* output.
                    if (i_fb_ready && !w_fill_last) begin
                        r_fy <= r_fy + YB_W'(1);
                    end
                end
                StNextCol: begin
                    if (!w_last_col) begin
                        r_col    <= r_col + X_W'(1);
                        r_samp_x <= r_samp_x + r_cstep_x;
                        r_samp_y <= r_samp_y + r_cstep_y;
                        r_wait   <= '0;
                    end else if (r_d != D_W'(DIST_STEPS)) begin
                        r_d <= r_d + D_W'(1);
                    end
                end
                StDone: r_done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_voxel_column_renderer.sv
// Directed bench for voxel_column_renderer in a 4x8 screen, 2-slice configuration.
module tb_voxel_column_renderer;
    import voxel_column_renderer_pkg::*;

    localparam int W = 4;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        reset, ack, done, fb_we, fb_ready;
    pos_t        cam_x, cam_y, lsx, lsy, psx, psy;
    logic [7:0]  cam_h, map_h;
    logic [8:0]  map_x, map_y;
    logic [2:0]  map_c, fb_y, fb_color;
    logic [1:0]  scale_addr, fb_x;
    logic [17:0] scale_q;
    logic [10:0] p1, p2;

    int scen;
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int t_acc = 0;
    int nwrites, done_rises, lat, n;
    logic done_prev = 1'b0;
    int wcnt [W][H];
    logic [2:0] wcol [W][H];
    logic [2:0] sx_y, sx_c;
    logic [1:0] sx_x;
    int snw;

    always #5 clk = ~clk;

    voxel_column_renderer #(
        .SCREEN_W   (W),
        .SCREEN_H   (H),
        .DIST_STEPS (2),
        .HORIZON_Y  (4),
        .SCALE_FRAC (8),
        .MAP_LAT    (2)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_render_ack  (ack),
        .o_render_done (done),
        .i_cam_x       (cam_x),
        .i_cam_y       (cam_y),
        .i_cam_height  (cam_h),
        .i_left_step_x (lsx),
        .i_left_step_y (lsy),
        .i_perp_step_x (psx),
        .i_perp_step_y (psy),
        .o_map_x       (map_x),
        .o_map_y       (map_y),
        .i_map_height  (map_h),
        .i_map_color   (map_c),
        .o_scale_addr  (scale_addr),
        .i_scale_q     (scale_q),
        .o_fb_we       (fb_we),
        .o_fb_x        (fb_x),
        .o_fb_y        (fb_y),
        .o_fb_color    (fb_color),
        .i_fb_ready    (fb_ready)
    );

    // Map contents per scenario: {height, colour}.
    function automatic logic [10:0] map_lookup(input int s, input logic [8:0] mx,
                                               input logic [8:0] my);
        case (s)
            0: return {8'd0, 3'd3};
            1: return {8'd6, 3'd5};
            2: return {8'd10, 3'd1};
            default: return {((mx == 9'd2 && my < 9'd5) ? 8'd6 : 8'd0), my[2:0]};
        endcase
    endfunction

    // Expected colour per pixel, -1 where nothing may be written.
    function automatic int exp_pix(input int s, input int x, input int y);
        case (s)
            0: return (y >= 6) ? 3 : -1;
            1: return 5;
            2: return 1;
            default: begin
                if (y >= 6) return x;
                if (x < 3) return 2 * x;
                return -1;
            end
        endcase
    endfunction

    // External memories: 2-cycle map pipe, 1-cycle scale ROM (zero at d=0).
    always @(posedge clk) begin
        p1 <= map_lookup(scen, map_x, map_y);
        p2 <= p1;
        scale_q <= (scale_addr != 2'd0) ? 18'd256 : 18'd0;
    end
    assign map_h = p2[10:3];
    assign map_c = p2[2:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Record the write committed at the coming posedge, then advance to the next negedge.
    task automatic cycle();
        if (fb_we && fb_ready) begin
            wcnt[fb_x][fb_y] = wcnt[fb_x][fb_y] + 1;
            wcol[fb_x][fb_y] = fb_color;
            nwrites++;
        end
        @(negedge clk);
        cyc++;
        if (done && !done_prev) done_rises++;
        done_prev = done;
    endtask

    task automatic clear_model();
        for (int x = 0; x < W; x++) begin
            for (int y = 0; y < H; y++) begin
                wcnt[x][y] = 0;
                wcol[x][y] = 3'd0;
            end
        end
        nwrites = 0;
        done_rises = 0;
    endtask

    task automatic start_frame(input int s, input logic [7:0] h);
        scen = s;
        cam_h = h;
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        t_acc = cyc;
        check("ack_clears_done", done, 0);
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        while (!done && (cyc - t_acc) < 2000) cycle();
        lat = cyc - t_acc;
        check(tag, lat, exp_lat);
    endtask

    task automatic check_frame(input int s);
        int e;
        int exp_n;
        exp_n = 0;
        for (int x = 0; x < W; x++) begin
            for (int y = 0; y < H; y++) begin
                e = exp_pix(s, x, y);
                if (e < 0) begin
                    check($sformatf("s%0d_cnt_%0d_%0d", s, x, y), wcnt[x][y], 0);
                end else begin
                    exp_n++;
                    check($sformatf("s%0d_cnt_%0d_%0d", s, x, y), wcnt[x][y], 1);
                    check($sformatf("s%0d_col_%0d_%0d", s, x, y), wcol[x][y], e);
                end
            end
        end
        check($sformatf("s%0d_writes", s), nwrites, exp_n);
        check($sformatf("s%0d_done_once", s), done_rises, 1);
    endtask

    initial begin
        reset = 1'b1;
        ack = 1'b0;
        fb_ready = 1'b1;
        scen = 0;
        cam_h = 8'd2;
        cam_x = '0;
        cam_y = '0;
        lsx = 32'sh0001_0000;
        lsy = '0;
        psx = '0;
        psy = 32'sh0001_0000;
        clear_model();
        @(negedge clk);
        cycle();
        cycle();
        check("rst_done", done, 0);
        check("rst_fb_we", fb_we, 0);
        check("rst_fb_x", fb_x, 0);
        check("rst_fb_y", fb_y, 0);
        check("rst_fb_color", fb_color, 0);
        check("rst_map_x", map_x, 0);
        check("rst_map_y", map_y, 0);
        check("rst_scale_addr", scale_addr, 0);
        reset = 1'b0;
        cycle();
        cycle();
        check("idle_no_done", done, 0);

        // Flat map: rows 6..7 on every column, second slice fully occluded.
        clear_model();
        start_frame(0, 8'd2);
        wait_done("flat_latency", 47);
        repeat (10) cycle();
        check("flat_done_held", done, 1);
        check_frame(0);

        // Tall terrain fills the whole column on slice 1.
        clear_model();
        start_frame(1, 8'd2);
        wait_done("tall_latency", 71);
        check_frame(1);

        // Projection above the top row clamps to row 0.
        clear_model();
        start_frame(2, 8'd2);
        wait_done("clamp_latency", 71);
        check_frame(2);

        // Address-dependent terrain: near slice low, far ridge occludes above it.
        clear_model();
        start_frame(3, 8'd2);
        wait_done("terrain_latency", 65);
        check_frame(3);

        // Framebuffer stall in the middle of a fill.
        clear_model();
        start_frame(0, 8'd2);
        n = 0;
        while (!fb_we && n < 200) begin
            cycle();
            n++;
        end
        check("stall_fill_seen", fb_we, 1);
        cycle();
        fb_ready = 1'b0;
        sx_x = fb_x;
        sx_y = fb_y;
        sx_c = fb_color;
        snw = nwrites;
        check("stall_x", sx_x, 0);
        check("stall_y", sx_y, 7);
        check("stall_color", sx_c, 3);
        repeat (3) begin
            cycle();
            check("stall_we", fb_we, 1);
            check("stall_x_hold", fb_x, sx_x);
            check("stall_y_hold", fb_y, sx_y);
            check("stall_c_hold", fb_color, sx_c);
        end
        check("stall_no_writes", nwrites, snw);
        fb_ready = 1'b1;
        wait_done("stall_latency", 50);
        check_frame(0);

        // Reset during a fill abandons the frame.
        clear_model();
        start_frame(0, 8'd2);
        n = 0;
        while (!fb_we && n < 200) begin
            cycle();
            n++;
        end
        check("rstfill_seen", fb_we, 1);
        reset = 1'b1;
        cycle();
        check("rstfill_we", fb_we, 0);
        check("rstfill_done", done, 0);
        reset = 1'b0;
        cycle();
        clear_model();
        start_frame(0, 8'd2);
        wait_done("rstfill_latency", 47);
        check_frame(0);

        // Ack pulsed while in ROW_INIT is ignored.
        clear_model();
        start_frame(0, 8'd2);
        repeat (4) cycle();
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        wait_done("ackign_latency", 47);
        repeat (10) cycle();
        check("ackign_done_held", done, 1);
        check_frame(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/voxel_column_renderer.md
Name: voxel_column_renderer

Overview:
- Parametrised, occlusion-correct successor to the single-pixel terrain renderer.
- Marches front-to-back over DIST_STEPS distance slices, one map sample per screen column per slice.
- Projects each sample to a screen row and fills the visible vertical span into the framebuffer, using a per-column y-buffer so nearer terrain hides farther terrain.
- Sits between the frame controller (render_ack/render_done handshake) and the framebuffer write port; map and height-scale memories are external.

Parameters:
- SCREEN_W, 320, columns per frame.
- SCREEN_H, 240, rows per frame.
- DIST_STEPS, 512, distance slices per frame (d = 1..DIST_STEPS).
- HORIZON_Y, 120, screen row of the horizon.
- POS_W, 32, signed fixed-point position/vector width.
- POS_FRAC, 16, fractional bits of POS_W quantities.
- MAP_AW, 9, map address bits per axis (map wraps modulo 2^MAP_AW).
- HEIGHT_W, 8, unsigned tile/camera height width.
- COLOR_W, 3, colour width.
- SCALE_W, 18, unsigned height-scale ROM word width.
- SCALE_FRAC, 8, fractional bits of scale word.
- MAP_LAT, 2, map read latency in cycles (>=1).

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous active-high reset.
- render_ack  in  1  start frame (sampled in IDLE only).
- render_done  out  1  frame complete; held until next accepted ack.
- cam_x, cam_y  in  POS_W  camera position; latched at ack.
- cam_height  in  HEIGHT_W  absolute eye height; latched at ack.
- left_step_x, left_step_y  in  POS_W  left-frustum-edge advance per slice; latched.
- perp_step_x, perp_step_y  in  POS_W  per-column advance per unit distance; latched.
- map_x, map_y  out  MAP_AW  map read address (integer part of sample position, truncated).
- map_height  in  HEIGHT_W  tile height, valid MAP_LAT cycles after address.
- map_color  in  COLOR_W  tile colour, same timing.
- scale_addr  out  log2(DIST_STEPS+1)  current slice d.
- scale_q  in  SCALE_W  ~K/d, valid 1 cycle after scale_addr.
- fb_we  out  1  framebuffer write strobe.
- fb_x  out  log2(SCREEN_W)  write column.
- fb_y  out  log2(SCREEN_H)  write row.
- fb_color  out  COLOR_W  write colour.
- fb_ready  in  1  framebuffer accepts the write this cycle.

Behaviour:
- Reset values: render_done=0, fb_we=0, fb_x/fb_y/fb_color=0, map_x/map_y=0, scale_addr=0, state=IDLE.
- Reset mid-frame: next cycle IDLE, fb_we=0, frame abandoned, render_done=0.
- IDLE: when render_ack=1, latch all frame inputs, clear render_done, go to CLEAR. Ack is ignored in every other state.
- CLEAR: write ybuf[c]=SCREEN_H for c=0..SCREEN_W-1 (SCREEN_W cycles). Set row_L = cam, col_step = 0, d = 1.
- ROW_INIT:
  - row_L += left_step.
  - col_step += perp_step.
  - sample = row_L, col = 0.
  - Drive scale_addr = d.
- FETCH: drive map_x/map_y from sample; wait MAP_LAT cycles; read ybuf[col].
- PROJECT:
  - diff = cam_height - map_height, signed HEIGHT_W+1.
  - y = HORIZON_Y + ((diff * scale_q) >>> SCALE_FRAC), full-precision signed product.
  - Clamp y to [0, SCREEN_H].
  - If y < ybuf[col], go to FILL with fy = y; otherwise go to NEXT_COL.
- FILL:
  - fb_we=1, fb_x=col, fb_y=fy, fb_color=map_color.
  - On each cycle with fb_ready=1: fy++. When fy reaches ybuf[col]-1, write ybuf[col]=y and go to NEXT_COL.
  - While fb_ready=0: all fb_* outputs hold stable, with no advance.
- NEXT_COL:
  - fb_we=0.
  - If col == SCREEN_W-1: if d == DIST_STEPS go to DONE, else d++ and go to ROW_INIT.
  - Otherwise: col++, sample += col_step, go to FETCH.
- DONE: render_done=1, go to IDLE.
- Map addressing wraps naturally (truncation to MAP_AW bits); negative positions wrap two's-complement.
- Monotonic occlusion: ybuf values never increase within a frame. Each (x,y) is written at most once per frame.
- Early termination is not performed; frame length depends only on parameters and the fill count.

Decomposition:
- Shared package holds:
  - the render state enum;
  - fixed-point pos typedef parametrised by POS_W/POS_FRAC;
  - screen coordinate typedef;
  - the clamp helper function.
- One sub-module: voxel_ybuffer, a SCREEN_W x log2(SCREEN_H+1) RAM with 1 read and 1 write port, inferred synchronous read, written during CLEAR and FILL.

Test Plan:
Small configuration for all scenarios: SCREEN_W=4, SCREEN_H=8, DIST_STEPS=2, HORIZON_Y=4, SCALE_FRAC=8, scale_q=256, MAP_LAT=2.
- Flat map, height 0, colour 3, cam_height 2 -> 8 writes (rows 6,7 per column 0..3, colour 3); slice d=2 gives y=6 >= ybuf, so no writes; render_done=1 and held.
- Uniform height 6, cam_height 2 -> y=0: 32 writes covering all rows, each (x,y) exactly once; d=2 produces zero writes.
- Height 10, cam_height 2 -> y=-4 clamped to 0; identical coverage to the previous case, no out-of-range fb_y.
- fb_ready held low 3 cycles mid-FILL -> fb_x/fb_y/fb_color stable across the stall, write count unchanged, frame completes with the same 8 writes as the flat case.
- Reset asserted during FILL -> next cycle fb_we=0, render_done=0; a following ack renders a full correct frame.
- render_ack pulsed during ROW_INIT -> ignored; exactly one render_done per accepted ack.
